// File: rtl/algofoogle_recip_pkg.sv
// algofoogle_recip_pkg: shared Q-format, beat and divider constants plus FSM state type (RECIP_ROUND_EN adds a rounding iteration)
package algofoogle_recip_pkg;
  localparam int INT_BITS = 6;
  localparam int FRAC_BITS = 10;
  localparam int IN_W = 4;
  localparam int OUT_W = 8;
  localparam int W = INT_BITS + FRAC_BITS;
  localparam int NIN = W / IN_W;
  localparam int NOUT = W / OUT_W;
`ifdef RECIP_ROUND_EN
  localparam int ITER = 2 * FRAC_BITS + 2;
`else
  localparam int ITER = 2 * FRAC_BITS + 1;
`endif
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam int CW = $clog2(ITER + 1);
  localparam int NIN_BW = NIN > 1 ? $clog2(NIN) : 1;
  localparam int NOUT_BW = NOUT > 1 ? $clog2(NOUT) : 1;
  typedef enum logic [1:0] {LOAD, CALC, FIX, EMIT} state_t;
endpackage

// File: rtl/algofoogle_recip_serial_divider.sv
// recip_divider_core: iterative restoring divide of the constant 2^(ITER-1) by mag, one quotient bit per clock
module recip_divider_core
  import algofoogle_recip_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [W-1:0]    mag,
  output logic            done,
  output logic [ITER-1:0] q
);
  logic busy;
  logic [CW-1:0] cnt;
  logic [W-1:0] rem;
  logic [W:0] trial, diff;
  logic ge;
  // the dividend is a single 1 in its MSB, so only the first iteration shifts in a 1
  always_comb begin
    trial = {rem, cnt == '0};
    diff = trial - {1'b0, mag};
    ge = trial >= {1'b0, mag};
    done = busy && cnt == CW'(ITER - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt <= '0;
      rem <= '0;
      q <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      rem <= '0;
      q <= '0;
    end else if (busy) begin
      rem <= ge ? diff[W-1:0] : trial[W-1:0];
      q <= {q[ITER-2:0], ge};
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/algofoogle_recip_serial.sv
// algofoogle_recip_serial: beat-serial signed fixed-point reciprocal with valid/ready on both sides (RECIP_ROUND_EN rounds half-up)
module algofoogle_recip_serial
  import algofoogle_recip_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_abs,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_sat,
  output logic             o_busy
);
  state_t state, state_n;
  logic [W-1:0] operand, result, mag, mv, res;
  logic [NIN_BW-1:0] icnt;
  logic [NOUT_BW-1:0] ocnt;
  logic abs_r, sat_r, neg, sat, start, done, in_last, out_last;
  logic [ITER-1:0] q, qv;
  recip_divider_core u_div (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mag   (mag),
    .done  (done),
    .q     (q)
  );
  always_comb begin
    neg = operand[W-1];
    mag = neg ? -operand : operand;
    in_last = icnt == NIN_BW'(NIN - 1);
    out_last = ocnt == NOUT_BW'(NOUT - 1);
    start = state == LOAD && i_valid && in_last;
`ifdef RECIP_ROUND_EN
    qv = (q + 1'b1) >> 1;
`else
    qv = q;
`endif
    sat = mag == '0 || qv > {{(ITER-W){1'b0}}, SAT_POS};
    mv = sat ? SAT_POS : qv[W-1:0];
    res = neg && !abs_r ? -mv : mv;
    state_n = state == LOAD ? (start ? CALC : LOAD) :
              state == CALC ? (done ? FIX : CALC) :
              state == FIX  ? EMIT :
              (i_ready && out_last ? LOAD : EMIT);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      operand <= '0;
      result <= '0;
      icnt <= '0;
      ocnt <= '0;
      abs_r <= 1'b0;
      sat_r <= 1'b0;
    end else begin
      state <= state_n;
      if (state == LOAD && i_valid) begin
        operand <= W'({operand, i_data});
        icnt <= in_last ? '0 : icnt + 1'b1;
        if (in_last) abs_r <= i_abs;
      end
      if (state == FIX) begin
        result <= res;
        sat_r <= sat;
        ocnt <= '0;
      end
      // the MS beat always sits at the top; accepted beats shift out
      if (state == EMIT && i_ready) begin
        result <= result << OUT_W;
        ocnt <= ocnt + 1'b1;
      end
    end
  end
  assign o_ready = state == LOAD;
  assign o_valid = state == EMIT;
  assign o_busy = state != LOAD;
  assign o_data = result[W-1 -: OUT_W];
  assign o_sat = sat_r;
endmodule

// File: tb/tb_algofoogle_recip_serial.sv
// tb_algofoogle_recip_serial: directed self-checking bench for the beat-serial reciprocal unit
module tb_algofoogle_recip_serial;
`ifdef RECIP_ROUND_EN
  localparam int LAT = 23;
`else
  localparam int LAT = 22;
`endif
  logic clk = 0, reset = 1, i_valid = 0, i_abs = 0, i_ready = 0;
  logic [3:0] i_data = 0;
  logic o_ready, o_valid, o_sat, o_busy;
  logic [7:0] o_data;
  int tests = 0, fails = 0;

  algofoogle_recip_serial dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_abs   (i_abs),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_sat   (o_sat),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [15:0] op, input logic ab);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i_valid = 1;
      i_data = op[15-4*i -: 4];
      i_abs = ab;
    end
    @(posedge clk);
    #1 i_valid = 0;
    i_abs = 0;
  endtask

  task automatic transact(input string name, input logic [15:0] op, input logic ab,
                          input logic [15:0] exp, input logic es, input int hold, input bit noise);
    int n = 0;
    send(op, ab);
    while (!o_valid && n < 60) begin
      @(posedge clk);
      #1 n++;
      i_valid = noise && (n == 3 || n == 9);
      i_data = 4'hF;
    end
    i_valid = 0;
    tests++;
    if (n !== LAT) begin fails++; $display("FAIL %s latency: got %0d want %0d", name, n, LAT); end
    tests++;
    if ({o_sat, o_data} !== {es, exp[15:8]})
      begin fails++; $display("FAIL %s beat0: got sat=%b data=%h want sat=%b data=%h", name, o_sat, o_data, es, exp[15:8]); end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1 tests++;
      if ({o_valid, o_data, o_sat} !== {1'b1, exp[15:8], es})
        begin fails++; $display("FAIL %s hold%0d: got v=%b data=%h sat=%b want v=1 data=%h sat=%b", name, k, o_valid, o_data, o_sat, exp[15:8], es); end
    end
    i_ready = 1;
    @(posedge clk);
    #1 tests++;
    if ({o_valid, o_data, o_sat} !== {1'b1, exp[7:0], es})
      begin fails++; $display("FAIL %s beat1: got v=%b data=%h sat=%b want v=1 data=%h sat=%b", name, o_valid, o_data, o_sat, exp[7:0], es); end
    @(posedge clk);
    #1 i_ready = 0;
    tests++;
    if ({o_ready, o_valid, o_busy} !== 3'b100)
      begin fails++; $display("FAIL %s done: got rdy/v/busy=%b want 100", name, {o_ready, o_valid, o_busy}); end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 tests++;
    if ({o_ready, o_valid, o_sat, o_busy, o_data} !== {4'b1000, 8'h00})
      begin fails++; $display("FAIL reset: got rdy/v/sat/busy=%b data=%h want 1000 00", {o_ready, o_valid, o_sat, o_busy}, o_data); end
    reset = 0;
  endtask

  task automatic test_basic;
    transact("one", 16'h0400, 0, 16'h0400, 0, 0, 0);
    transact("two", 16'h0800, 0, 16'h0200, 0, 0, 0);
    transact("quarter", 16'h0100, 0, 16'h1000, 0, 0, 0);
    transact("three_q", 16'h0300, 0, 16'h0555, 0, 0, 0);
  endtask

  task automatic test_sign;
    transact("neg_two", 16'hF800, 0, 16'hFE00, 0, 0, 0);
    transact("neg_two_abs", 16'hF800, 1, 16'h0200, 0, 0, 0);
    transact("most_neg", 16'h8000, 0, 16'hFFE0, 0, 0, 0);
  endtask

  task automatic test_saturation;
    transact("zero", 16'h0000, 0, 16'h7FFF, 1, 0, 0);
    transact("lsb", 16'h0001, 0, 16'h7FFF, 1, 0, 0);
    transact("neg_lsb", 16'hFFFF, 0, 16'h8001, 1, 0, 0);
  endtask

  task automatic test_backpressure;
    transact("hold", 16'h0300, 0, 16'h0555, 0, 5, 0);
    transact("noise", 16'h0800, 0, 16'h0200, 0, 0, 1);
  endtask

  task automatic test_abort;
    send(16'h0100, 0);
    repeat (5) @(posedge clk);
    #1 tests++;
    if ({o_ready, o_busy} !== 2'b01)
      begin fails++; $display("FAIL calc_busy: got rdy/busy=%b want 01", {o_ready, o_busy}); end
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    tests++;
    if ({o_ready, o_valid, o_busy} !== 3'b100)
      begin fails++; $display("FAIL abort: got rdy/v/busy=%b want 100", {o_ready, o_valid, o_busy}); end
    transact("after_abort", 16'h0400, 0, 16'h0400, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sign;
    test_saturation;
    test_backpressure;
    test_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
